// File: rtl/multdiv_sequencer_pkg.sv
// Shared types and defaults for the multiply/divide timing sequencer.
package multdiv_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  localparam int unsigned DEF_CNT_W    = 6;
  localparam int unsigned DEF_MULT_LAT = 32;
  localparam int unsigned DEF_DIV_LAT  = 33;
  localparam int unsigned DEF_WE_GAP   = 1;

  function automatic int unsigned max_lat(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/multdiv_sequencer_cycle_counter.sv
// Binary iteration counter: synchronous clear has priority over enable.
module multdiv_sequencer_cycle_counter #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d, count_q;

  // NOTE: combinational blocks assign a default first so no path leaves a signal unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/multdiv_sequencer.sv
// Timing sequencer for the iterative multiplier/divider: FSM plus binary iteration
// counter producing datapath init/step and the writeback ready/we pair.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned MULT_LAT = DEF_MULT_LAT,
  parameter int unsigned DIV_LAT  = DEF_DIV_LAT,
  parameter int unsigned WE_GAP   = DEF_WE_GAP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic             hold,
  input  logic             cancel,
  output logic             busy,
  output logic             op_is_div,
  output logic             init,
  output logic             step,
  output logic             ready,
  output logic             we,
  output logic             op_err,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned MaxLat = max_lat(MULT_LAT, DIV_LAT);

  if ((MULT_LAT < 1) || (DIV_LAT < 1) || (MaxLat > ((1 << CNT_W) - 1))) begin : g_bad_cfg
    $error("multdiv_sequencer: latencies must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] MultLast = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DivLast  = CNT_W'(DIV_LAT - 1);
  localparam bit               WbStage  = (WE_GAP != 0);

  state_e           state_d, state_q;
  logic             op_is_div_d, op_is_div_q;
  logic             init_d, init_q;
  logic             op_err_d, op_err_q;
  logic             cnt_clr, cnt_en;
  logic             start, both;
  logic [CNT_W-1:0] last_cnt;

  assign start    = ctrl_mult ^ ctrl_div;
  assign both     = ctrl_mult & ctrl_div;
  assign last_cnt = op_is_div_q ? DivLast : MultLast;

  // Priority: illegal op > start (restart) > cancel > hold > normal advance.
  always_comb begin
    state_d     = state_q;
    op_is_div_d = op_is_div_q;
    init_d      = init_q;
    op_err_d    = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    if (both) begin
      state_d  = ST_IDLE;
      init_d   = 1'b0;
      op_err_d = 1'b1;
      cnt_clr  = 1'b1;
    end else if (start) begin
      state_d     = ST_RUN;
      op_is_div_d = ctrl_div;
      init_d      = 1'b1;
      cnt_clr     = 1'b1;
    end else if (cancel) begin
      state_d = ST_IDLE;
      init_d  = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!hold) begin
            init_d = 1'b0;
            cnt_en = 1'b1;
            if (count == last_cnt) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (WbStage) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
          end
        end
        ST_WB: begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_is_div_q <= 1'b0;
      init_q      <= 1'b0;
      op_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_is_div_q <= op_is_div_d;
      init_q      <= init_d;
      op_err_q    <= op_err_d;
    end
  end

  multdiv_sequencer_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .count  (count)
  );

  // step is the only output that sees an input: the datapath stall gates it directly.
  assign busy      = (state_q != ST_IDLE);
  assign op_is_div = op_is_div_q;
  assign init      = init_q;
  assign step      = (state_q == ST_RUN) && !hold;
  assign ready     = (state_q == ST_DONE);
  assign we        = WbStage ? (state_q == ST_WB) : (state_q == ST_DONE);
  assign op_err    = op_err_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: WE_GAP=1 and WE_GAP=0 instances share stimulus.
module tb_multdiv_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ctrl_mult = 1'b0, ctrl_div = 1'b0, hold = 1'b0, cancel = 1'b0;

  logic       busy, op_is_div, init, step, ready, we, op_err;
  logic [5:0] count;
  logic       busy_0, op_is_div_0, init_0, step_0, ready_0, we_0, op_err_0;
  logic [5:0] count_0;

  int checks   = 0;
  int failures = 0;

  logic [5:0] cnt_log   [0:79];
  logic       opdiv_log [0:79];
  logic       init_log  [0:79];
  logic       err_log   [0:79];
  logic       busy_log  [0:79];
  int ready_at, ready_n, we_at, we_n, busy_n, step_n, overlap_n;
  int ready0_at, we0_at, we0_n;

  multdiv_sequencer #(.CNT_W(6), .MULT_LAT(32), .DIV_LAT(33), .WE_GAP(1)) dut (
    .clock(clock), .reset(reset), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .hold(hold), .cancel(cancel), .busy(busy), .op_is_div(op_is_div), .init(init),
    .step(step), .ready(ready), .we(we), .op_err(op_err), .count(count)
  );

  multdiv_sequencer #(.CNT_W(6), .MULT_LAT(32), .DIV_LAT(33), .WE_GAP(0)) dut0 (
    .clock(clock), .reset(reset), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .hold(hold), .cancel(cancel), .busy(busy_0), .op_is_div(op_is_div_0), .init(init_0),
    .step(step_0), .ready(ready_0), .we(we_0), .op_err(op_err_0), .count(count_0)
  );

  always #5 clock = ~clock;

  // Launch an op at edge 0, then log outputs at the negedge after each edge i (index i).
  // A hold window and a one-cycle mid-run event are driven at negedge i for edge i+1.
  task automatic run_op(input logic m, input logic d, input int hold_from, input int hold_len,
                        input int ev_at, input logic ev_m, input logic ev_d, input logic ev_c,
                        input int ncyc);
    ready_at = -1; ready_n = 0; we_at = -1; we_n = 0; busy_n = 0; step_n = 0; overlap_n = 0;
    ready0_at = -1; we0_at = -1; we0_n = 0;
    @(negedge clock);
    ctrl_mult = m; ctrl_div = d;
    @(negedge clock);
    ctrl_mult = 1'b0; ctrl_div = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      cnt_log[i] = count; opdiv_log[i] = op_is_div; init_log[i] = init;
      err_log[i] = op_err; busy_log[i] = busy;
      if (ready) begin if (ready_at < 0) ready_at = i; ready_n++; end
      if (we) begin if (we_at < 0) we_at = i; we_n++; end
      if (busy) busy_n++;
      if (step) step_n++;
      if (init && (ready || we)) overlap_n++;
      if (ready_0 && ready0_at < 0) ready0_at = i;
      if (we_0) begin if (we0_at < 0) we0_at = i; we0_n++; end
      hold      = (i >= hold_from) && (i < hold_from + hold_len);
      ctrl_mult = (i == ev_at) && ev_m;
      ctrl_div  = (i == ev_at) && ev_d;
      cancel    = (i == ev_at) && ev_c;
      @(negedge clock);
    end
    hold = 1'b0; cancel = 1'b0; ctrl_mult = 1'b0; ctrl_div = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if ({busy, op_is_div, init, step, ready, we, op_err, count} !== 13'd0) begin
      failures++; $display("FAIL reset_outputs: got %b expected 0", {busy, op_is_div, init, step, ready, we, op_err, count}); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_mult();
    run_op(1'b1, 1'b0, -1, 0, -1, 1'b0, 1'b0, 1'b0, 40);
    checks++; if (ready_at !== 32) begin failures++; $display("FAIL mult_ready_at: got %0d expected 32", ready_at); end
    checks++; if (we_at !== 33) begin failures++; $display("FAIL mult_we_at: got %0d expected 33", we_at); end
    checks++; if (busy_n !== 34) begin failures++; $display("FAIL mult_busy_cycles: got %0d expected 34", busy_n); end
    checks++; if (ready_n !== 1 || we_n !== 1) begin failures++; $display("FAIL mult_pulses: got ready=%0d we=%0d expected 1/1", ready_n, we_n); end
    checks++; if (step_n !== 32) begin failures++; $display("FAIL mult_steps: got %0d expected 32", step_n); end
    checks++; if (cnt_log[32] !== 6'd32) begin failures++; $display("FAIL mult_count_done: got %0d expected 32", cnt_log[32]); end
    checks++; if (init_log[0] !== 1'b1 || init_log[1] !== 1'b0) begin failures++; $display("FAIL mult_init: got %b%b expected 10", init_log[0], init_log[1]); end
    checks++; if (opdiv_log[0] !== 1'b0) begin failures++; $display("FAIL mult_op_is_div: got %b expected 0", opdiv_log[0]); end
    checks++; if (cnt_log[35] !== 6'd0 || busy_log[34] !== 1'b0) begin failures++; $display("FAIL mult_idle_after: got count=%0d busy=%b expected 0/0", cnt_log[35], busy_log[34]); end
    checks++; if (overlap_n !== 0) begin failures++; $display("FAIL mult_init_overlap: got %0d expected 0", overlap_n); end
  endtask

  task automatic test_div_hold();
    run_op(1'b0, 1'b1, 10, 5, -1, 1'b0, 1'b0, 1'b0, 45);
    checks++; if (ready_at !== 38) begin failures++; $display("FAIL hold_ready_at: got %0d expected 38", ready_at); end
    checks++; if (we_at !== 39) begin failures++; $display("FAIL hold_we_at: got %0d expected 39", we_at); end
    checks++; if (cnt_log[15] !== 6'd10 || cnt_log[16] !== 6'd11) begin failures++; $display("FAIL hold_count_frozen: got %0d,%0d expected 10,11", cnt_log[15], cnt_log[16]); end
    checks++; if (step_n !== 33) begin failures++; $display("FAIL hold_steps: got %0d expected 33", step_n); end
    checks++; if (opdiv_log[0] !== 1'b1 || cnt_log[38] !== 6'd33) begin failures++; $display("FAIL hold_div_final: got div=%b count=%0d expected 1/33", opdiv_log[0], cnt_log[38]); end
  endtask

  task automatic test_restart();
    run_op(1'b1, 1'b0, -1, 0, 10, 1'b0, 1'b1, 1'b0, 55);
    checks++; if (cnt_log[10] !== 6'd10 || cnt_log[11] !== 6'd0) begin failures++; $display("FAIL restart_count: got %0d,%0d expected 10,0", cnt_log[10], cnt_log[11]); end
    checks++; if (opdiv_log[11] !== 1'b1 || init_log[11] !== 1'b1) begin failures++; $display("FAIL restart_mode: got div=%b init=%b expected 1/1", opdiv_log[11], init_log[11]); end
    checks++; if (ready_at !== 44 || we_at !== 45) begin failures++; $display("FAIL restart_latency: got ready=%0d we=%0d expected 44/45", ready_at, we_at); end
    checks++; if (ready_n !== 1 || we_n !== 1) begin failures++; $display("FAIL restart_pulses: got ready=%0d we=%0d expected 1/1", ready_n, we_n); end
  endtask

  task automatic test_cancel();
    run_op(1'b1, 1'b0, -1, 0, 20, 1'b0, 1'b0, 1'b1, 45);
    checks++; if (busy_log[21] !== 1'b0 || cnt_log[21] !== 6'd0) begin failures++; $display("FAIL cancel_idle: got busy=%b count=%0d expected 0/0", busy_log[21], cnt_log[21]); end
    checks++; if (ready_n !== 0 || we_n !== 0 || we0_n !== 0) begin failures++; $display("FAIL cancel_no_wb: got ready=%0d we=%0d we0=%0d expected 0/0/0", ready_n, we_n, we0_n); end
    run_op(1'b1, 1'b0, -1, 0, -1, 1'b0, 1'b0, 1'b0, 40);
    checks++; if (ready_at !== 32 || we_at !== 33) begin failures++; $display("FAIL cancel_next_op: got ready=%0d we=%0d expected 32/33", ready_at, we_at); end
  endtask

  task automatic test_op_err();
    run_op(1'b1, 1'b1, -1, 0, -1, 1'b0, 1'b0, 1'b0, 10);
    checks++; if (err_log[0] !== 1'b1 || err_log[1] !== 1'b0) begin failures++; $display("FAIL err_pulse: got %b%b expected 10", err_log[0], err_log[1]); end
    checks++; if (busy_n !== 0 || step_n !== 0 || ready_n !== 0) begin failures++; $display("FAIL err_idle: got busy=%0d step=%0d ready=%0d expected 0/0/0", busy_n, step_n, ready_n); end
    run_op(1'b1, 1'b0, -1, 0, 5, 1'b1, 1'b1, 1'b0, 40);
    checks++; if (err_log[6] !== 1'b1 || busy_log[6] !== 1'b0 || cnt_log[6] !== 6'd0) begin failures++; $display("FAIL err_midrun: got err=%b busy=%b count=%0d expected 1/0/0", err_log[6], busy_log[6], cnt_log[6]); end
    checks++; if (ready_n !== 0 || we_n !== 0) begin failures++; $display("FAIL err_midrun_no_wb: got ready=%0d we=%0d expected 0/0", ready_n, we_n); end
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, 1'b0, -1, 0, 32, 1'b1, 1'b0, 1'b0, 70);
    checks++; if (ready_n !== 2) begin failures++; $display("FAIL b2b_ready_pulses: got %0d expected 2", ready_n); end
    checks++; if (we_n !== 1 || we_at !== 66) begin failures++; $display("FAIL b2b_we: got n=%0d at=%0d expected 1 at 66", we_n, we_at); end
    checks++; if (we0_n !== 2) begin failures++; $display("FAIL b2b_we_gap0: got %0d expected 2", we0_n); end
    checks++; if (overlap_n !== 0) begin failures++; $display("FAIL b2b_init_overlap: got %0d expected 0", overlap_n); end
  endtask

  task automatic test_we_gap0_and_async_reset();
    run_op(1'b1, 1'b0, -1, 0, -1, 1'b0, 1'b0, 1'b0, 40);
    checks++; if (ready0_at !== 32 || we0_at !== 32) begin failures++; $display("FAIL gap0_coincide: got ready=%0d we=%0d expected 32/32", ready0_at, we0_at); end
    @(negedge clock);
    ctrl_div = 1'b1;
    @(negedge clock);
    ctrl_div = 1'b0;
    repeat (10) @(negedge clock);
    checks++; if (count !== 6'd10 || op_is_div !== 1'b1) begin failures++; $display("FAIL areset_pre: got count=%0d div=%b expected 10/1", count, op_is_div); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({busy, op_is_div, init, step, ready, we, op_err, count} !== 13'd0 ||
                  {busy_0, op_is_div_0, init_0, step_0, ready_0, we_0, op_err_0, count_0} !== 13'd0) begin
      failures++; $display("FAIL areset_outputs: got %b / %b expected 0", {busy, op_is_div, init, step, ready, we, op_err, count},
                           {busy_0, op_is_div_0, init_0, step_0, ready_0, we_0, op_err_0, count_0}); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_hold();
    test_restart();
    test_cancel();
    test_op_err();
    test_back_to_back();
    test_we_gap0_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
